xadc_drp_responder: RTL and testbench
=====================================

Name: xadc_drp_responder

Overview:
- Synthesizable DRP responder model of the XADC dynamic reconfiguration port, used in simulation benches and hardware loopback builds in place of the hard XADC primitive.
- Runs an internal conversion sequencer over the Arty analog channel addresses and stores ramped results in status registers.
- Emits eoc/eos/channel strobes and answers DRP reads/writes with drdy after a fixed latency.

Parameters:
- RD_LATENCY, 4, cycles from accepted den to drdy_out pulse (legal 1..15)
- CONV_CYCLES, 26, clock cycles per conversion (legal 4..255)
- RAMP_SHIFT, 4, left shift applied to the 12-bit ramp code when placing it into the 16-bit result

Ports:
- CLK100MHZ  in  1  sole clock; DRP and sequencer domain
- reset_in  in  1  asynchronous, active-high reset
- daddr_in  in  7  DRP address
- den_in  in  1  DRP enable, single-cycle request strobe
- dwe_in  in  1  DRP write enable, qualified by den_in
- di_in  in  16  DRP write data
- do_out  out  16  DRP read data, valid only while drdy_out=1
- drdy_out  out  1  one-cycle transaction-complete pulse
- busy_out  out  1  high while a conversion is in progress
- channel_out  out  5  channel of the most recently completed conversion (daddr_in[4:0] encoding)
- eoc_out  out  1  one-cycle end-of-conversion pulse
- eos_out  out  1  one-cycle end-of-sequence pulse, coincident with the last eoc_out

Behaviour:
- Reset (async assert, sync deassert): all outputs 0, all registers 0, ramp codes 0, sequencer index 0, DRP FSM IDLE.
- Sequence list, fixed order: 0x14, 0x15, 0x16, 0x17, 0x1F, 0x10, 0x1C, 0x1D, 0x1E, then wrap to index 0.
- Sequencer FSM:
  - States: WAIT (1 cycle after reset) -> CONV (CONV_CYCLES cycles, busy_out=1) -> DONE (1 cycle, busy_out=0) -> CONV.
  - In DONE: ramp[idx] <= ramp[idx] + (idx+1), mod 4096.
  - Status register at list[idx] <= {ramp_new, zeros} << RAMP_SHIFT, truncated to 16 bits.
  - In DONE: eoc_out=1, channel_out=list[idx].
  - eos_out=1 when idx==8; idx wraps 8 -> 0.
- Register map:
  - 0x00-0x3F: status, read-only.
  - 0x40-0x7F: config, read/write.
  - Unwritten addresses read 0.
- DRP FSM:
  - States: IDLE -> WAIT (RD_LATENCY-1 cycles) -> RESP (drdy_out=1 for one cycle) -> IDLE.
  - With RD_LATENCY=1, WAIT is skipped.
  - Request accepted only in IDLE when den_in=1.
  - Address, dwe_in, di_in and the read data are all snapshotted at acceptance.
- Read: do_out carries the snapshot; it is not updated by a conversion completing during WAIT. do_out = 0 whenever drdy_out=0.
- Write:
  - Config region: register updated at acceptance.
  - Status region: write ignored.
  - drdy_out pulses after RD_LATENCY in both cases; do_out = 0.
- den_in while not IDLE: ignored entirely, with no queuing and no extra drdy_out.
- Conversion DONE and an accepted read to the same address in the same cycle: the read returns the pre-update value.
- reset_in mid-transaction: the in-flight request is aborted and no drdy_out is issued after reset release.
- Back-to-back requests: the next den_in can be accepted on the cycle after drdy_out, giving a minimum period of RD_LATENCY+1 cycles.
- Latency check: den_in sampled at cycle t gives drdy_out at t+RD_LATENCY.

Optional Feature:
- Macro: XADC_DRP_ERR_EN.
- Defined: adds output drp_err_out (1 bit), sticky.
  - Set on den_in while not IDLE, or on an accepted write to 0x00-0x3F.
  - Cleared only by reset_in or by a write to 0x7F with di_in[0]=1.
- Undefined: port and logic are absent; the same events are silently ignored as described above.

Decomposition:
- Package xadc_drp_pkg:
  - DRP_ADDR_W=7, DRP_DATA_W=16, CH_W=5
  - Sequence-list constant array (9 x 7-bit)
  - STATUS_LIMIT=0x40
  - DRP FSM state typedef; sequencer FSM state typedef
- Sub-module xadc_seq_model: sequencer FSM, ramp counters, eoc/eos/channel/busy generation, and a write port into the register file.
- Top module: register file and DRP FSM.

Test Plan:
- Reset release, default parameters -> first eoc_out 28 cycles after release with channel_out=0x14; DRP read of 0x14 returns 0x0010 with drdy_out 4 cycles after den_in.
- Run 9 conversions -> eos_out only with the 9th eoc_out (channel_out=0x1E); the 10th conversion has channel_out=0x14 and 0x14 reads 0x0020.
- Write 0xBEEF to 0x45 then read 0x45 -> 0xBEEF; write 0x1234 to 0x14 -> drdy_out pulses and 0x14 is unchanged.
- den_in at t and t+2 -> exactly one drdy_out, at t+4; with XADC_DRP_ERR_EN, drp_err_out=1 from t+3.
- Read 0x14 accepted in the same cycle as its DONE -> returns the previous value (0x0000 for the first conversion).
- reset_in asserted 2 cycles after den_in -> all outputs 0 immediately; no drdy_out for 20 cycles after release other than for new requests.

Source files
------------

// File: rtl/xadc_drp_responder_pkg.sv
// xadc_drp_pkg: shared widths, conversion sequence list and FSM state types for the XADC DRP responder
package xadc_drp_pkg;
    localparam int DRP_ADDR_W = 7;
    localparam int DRP_DATA_W = 16;
    localparam int CH_W = 5;
    localparam int SEQ_LEN = 9;
    localparam logic [DRP_ADDR_W-1:0] STATUS_LIMIT = 7'h40;
    localparam logic [DRP_ADDR_W-1:0] SEQ_LIST [SEQ_LEN] = '{
        7'h14, 7'h15, 7'h16, 7'h17, 7'h1F, 7'h10, 7'h1C, 7'h1D, 7'h1E
    };
    typedef enum logic [1:0] {DRP_IDLE, DRP_WAIT, DRP_RESP} drp_state_t;
    typedef enum logic [1:0] {SEQ_WAIT, SEQ_CONV, SEQ_DONE} seq_state_t;
endpackage

// File: rtl/xadc_drp_responder_seq_model.sv
// xadc_seq_model: conversion sequencer producing ramped status results and eoc/eos/channel strobes
module xadc_seq_model
    import xadc_drp_pkg::*;
#(
    parameter int CONV_CYCLES = 26,
    parameter int RAMP_SHIFT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    output logic                  eoc,
    output logic                  eos,
    output logic [CH_W-1:0]       channel,
    output logic                  wr_en,
    output logic [DRP_ADDR_W-1:0] wr_addr,
    output logic [DRP_DATA_W-1:0] wr_data
);
    seq_state_t state, state_nx;
    logic [7:0] cnt;
    logic [3:0] idx;
    logic [11:0] ramp [SEQ_LEN];
    logic [11:0] ramp_nx;

    assign ramp_nx = ramp[idx] + 12'(idx) + 12'd1;
    assign busy = state == SEQ_CONV;
    assign wr_en = state == SEQ_DONE;
    assign wr_addr = SEQ_LIST[idx];
    assign wr_data = DRP_DATA_W'(ramp_nx) << RAMP_SHIFT;

    // state register plus conversion cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEQ_WAIT;
            cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= state == SEQ_CONV ? cnt + 8'd1 : '0;
        end
    end

    // WAIT and DONE both fall into CONV; CONV ends after CONV_CYCLES cycles
    always_comb begin
        state_nx = state;
        state_nx = state != SEQ_CONV ? SEQ_CONV : cnt == 8'(CONV_CYCLES - 1) ? SEQ_DONE : SEQ_CONV;
    end

    // completion bookkeeping: ramp advance, strobes, channel and list index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SEQ_LEN; i++) ramp[i] <= '0;
            idx <= '0;
            eoc <= 1'b0;
            eos <= 1'b0;
            channel <= '0;
        end else begin
            eoc <= wr_en;
            eos <= wr_en && idx == 4'(SEQ_LEN - 1);
            if (wr_en) begin
                ramp[idx] <= ramp_nx;
                channel <= wr_addr[CH_W-1:0];
                idx <= idx == 4'(SEQ_LEN - 1) ? '0 : idx + 4'd1;
            end
        end
    end
endmodule

// File: rtl/xadc_drp_responder.sv
// xadc_drp_responder: DRP register file and fixed-latency responder; XADC_DRP_ERR_EN adds sticky drp_err_out
module xadc_drp_responder
    import xadc_drp_pkg::*;
#(
    parameter int RD_LATENCY = 4,
    parameter int CONV_CYCLES = 26,
    parameter int RAMP_SHIFT = 4
) (
    input  logic                  CLK100MHZ,
    input  logic                  reset_in,
    input  logic [DRP_ADDR_W-1:0] daddr_in,
    input  logic                  den_in,
    input  logic                  dwe_in,
    input  logic [DRP_DATA_W-1:0] di_in,
    output logic [DRP_DATA_W-1:0] do_out,
    output logic                  drdy_out,
    output logic                  busy_out,
    output logic [CH_W-1:0]       channel_out,
    output logic                  eoc_out,
    output logic                  eos_out
`ifdef XADC_DRP_ERR_EN
    ,
    output logic                  drp_err_out
`endif
);
    localparam drp_state_t FIRST = RD_LATENCY == 1 ? DRP_RESP : DRP_WAIT;

    drp_state_t state, state_nx;
    logic [3:0] cnt;
    logic [DRP_DATA_W-1:0] regs [2**DRP_ADDR_W];
    logic [DRP_DATA_W-1:0] rdata;
    logic accept, cfg_we, seq_we;
    logic [DRP_ADDR_W-1:0] seq_addr;
    logic [DRP_DATA_W-1:0] seq_data;

    xadc_seq_model #(.CONV_CYCLES(CONV_CYCLES), .RAMP_SHIFT(RAMP_SHIFT)) u_seq (
        .clk(CLK100MHZ),
        .rst(reset_in),
        .busy(busy_out),
        .eoc(eoc_out),
        .eos(eos_out),
        .channel(channel_out),
        .wr_en(seq_we),
        .wr_addr(seq_addr),
        .wr_data(seq_data)
    );

    assign accept = state == DRP_IDLE && den_in;
    assign cfg_we = accept && dwe_in && daddr_in >= STATUS_LIMIT;
    assign drdy_out = state == DRP_RESP;
    assign do_out = drdy_out ? rdata : '0;

    // DRP state register and latency counter
    always_ff @(posedge CLK100MHZ or posedge reset_in) begin
        if (reset_in) begin
            state <= DRP_IDLE;
            cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= state == DRP_WAIT ? cnt + 4'd1 : '0;
        end
    end

    // IDLE accepts, WAIT burns RD_LATENCY-1 cycles, RESP lasts one cycle
    always_comb begin
        state_nx = state;
        state_nx = state == DRP_IDLE ? (den_in ? FIRST : DRP_IDLE)
                 : state == DRP_WAIT ? (cnt == 4'(RD_LATENCY - 2) ? DRP_RESP : DRP_WAIT)
                 : DRP_IDLE;
    end

    // read data is captured at acceptance so later conversions cannot change it
    always_ff @(posedge CLK100MHZ or posedge reset_in) begin
        if (reset_in) rdata <= '0;
        else if (accept) rdata <= dwe_in ? '0 : regs[daddr_in];
    end

    // status half written by the sequencer, config half by DRP writes
    always_ff @(posedge CLK100MHZ or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < 2**DRP_ADDR_W; i++) regs[i] <= '0;
        end else begin
            if (seq_we) regs[seq_addr] <= seq_data;
            if (cfg_we) regs[daddr_in] <= di_in;
        end
    end

`ifdef XADC_DRP_ERR_EN
    // sticky protocol error: busy collision or status write; cleared by writing 1 to 0x7F
    always_ff @(posedge CLK100MHZ or posedge reset_in) begin
        if (reset_in) drp_err_out <= 1'b0;
        else if ((den_in && state != DRP_IDLE) || (accept && dwe_in && daddr_in < STATUS_LIMIT)) drp_err_out <= 1'b1;
        else if (cfg_we && daddr_in == 7'h7F && di_in[0]) drp_err_out <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_xadc_drp_responder.sv
// tb_xadc_drp_responder: directed plus random DRP traffic checked against an arithmetic timing/value model
module tb_xadc_drp_responder;
    logic clk = 1'b0;
    logic rst, den, dwe, drdy, busy, eoc, eos;
    logic [6:0] daddr;
    logic [15:0] di, dout;
    logic [4:0] chan;
`ifdef XADC_DRP_ERR_EN
    logic drp_err;
`endif
    int total = 0, bad = 0, cyc = 0;
    bit seq_on = 0;
    int lst [9] = '{'h14, 'h15, 'h16, 'h17, 'h1F, 'h10, 'h1C, 'h1D, 'h1E};
    logic [15:0] cfg [64];
    logic [15:0] last_rd;

    always #5 clk = ~clk;

    xadc_drp_responder dut (
        .CLK100MHZ(clk),
        .reset_in(rst),
        .daddr_in(daddr),
        .den_in(den),
        .dwe_in(dwe),
        .di_in(di),
        .do_out(dout),
        .drdy_out(drdy),
        .busy_out(busy),
        .channel_out(chan),
        .eoc_out(eoc),
        .eos_out(eos)
`ifdef XADC_DRP_ERR_EN
        ,
        .drp_err_out(drp_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // conversion j completes on edge 28+27*j; a read sampled on edge e sees completions before e
    function automatic logic [15:0] stat(input int a, input int e);
        int n, nk;
        n = e >= 29 ? (e - 29) / 27 + 1 : 0;
        for (int k = 0; k < 9; k++)
            if (lst[k] == a) begin
                nk = n > k ? (n - 1 - k) / 9 + 1 : 0;
                return 16'(((nk * (k + 1)) % 4096) * 16);
            end
        return 16'h0;
    endfunction

    task automatic tick();
        int j;
        bit e;
        @(posedge clk);
        cyc++;
        #1;
        if (seq_on) begin
            e = cyc >= 28 && (cyc - 28) % 27 == 0;
            j = cyc >= 28 ? (cyc - 28) / 27 : 0;
            chk("eoc", 32'(eoc), 32'(e));
            chk("eos", 32'(eos), 32'(e && j % 9 == 8));
            chk("chan", 32'(chan), cyc >= 28 ? lst[j % 9] & 31 : 0);
            chk("busy", 32'(busy), 32'(!(cyc >= 27 && (cyc - 27) % 27 == 0)));
        end
    endtask

    task automatic do_txn(input logic [6:0] a, input bit we, input logic [15:0] d);
        logic [15:0] exp;
        int n, ai;
        ai = int'(a);
        daddr = a; dwe = we; di = d; den = 1'b1;
        tick();
        den = 1'b0; dwe = 1'b0;
        exp = we ? 16'h0 : ai >= 64 ? cfg[ai - 64] : stat(ai, cyc);
        if (we && ai >= 64) cfg[ai - 64] = d;
        n = 0;
        while (!drdy && n < 20) begin
            tick();
            n++;
        end
        chk("latency", n, 3);
        chk("rdata", 32'(dout), 32'(exp));
        last_rd = dout;
        tick();
        chk("drdy_clr", 32'(drdy), 0);
        chk("do_clr", 32'(dout), 0);
    endtask

    task automatic release_rst();
        rst = 1'b0;
        cyc = 0;
        seq_on = 1;
        for (int i = 0; i < 64; i++) cfg[i] = '0;
    endtask

    initial begin
        int p, first, a0, r;
        rst = 1'b1; den = 0; dwe = 0; daddr = '0; di = '0;
        repeat (3) tick();
        chk("rst_drdy", 32'(drdy), 0);
        chk("rst_do", 32'(dout), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_eoc", 32'(eoc), 0);
        chk("rst_eos", 32'(eos), 0);
        chk("rst_chan", 32'(chan), 0);
        release_rst();
        while (cyc < 27) tick();
        do_txn(7'h14, 0, 0);
        chk("done_same_cycle", 32'(last_rd), 32'h0);
        do_txn(7'h14, 0, 0);
        chk("first_conv", 32'(last_rd), 32'h0010);
        do_txn(7'h45, 1, 16'hBEEF);
        do_txn(7'h45, 0, 0);
        chk("cfg_rw", 32'(last_rd), 32'hBEEF);
        do_txn(7'h14, 1, 16'h1234);
        do_txn(7'h14, 0, 0);
        chk("status_ro", 32'(last_rd), 32'h0010);
        daddr = 7'h15; den = 1'b1;
        tick();
        a0 = cyc;
        den = 1'b0;
        tick();
        chk("coll_drdy1", 32'(drdy), 0);
        den = 1'b1;
        tick();
        den = 1'b0;
        chk("coll_drdy2", 32'(drdy), 0);
`ifdef XADC_DRP_ERR_EN
        chk("err_set", 32'(drp_err), 1);
`endif
        p = 0; first = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (drdy) begin
                p++;
                if (first < 0) first = cyc - a0;
            end
        end
        chk("coll_count", p, 1);
        chk("coll_lat", first, 3);
`ifdef XADC_DRP_ERR_EN
        do_txn(7'h7F, 1, 16'h0001);
        chk("err_clr", 32'(drp_err), 0);
`endif
        while (cyc < 272) tick();
        do_txn(7'h14, 0, 0);
        chk("wrap_14", 32'(last_rd), 32'h0020);
        for (int t = 0; t < 40; t++) begin
            r = int'($urandom_range(0, 3));
            case (r)
                0: do_txn(7'(lst[$urandom_range(0, 8)]), 0, 0);
                1: do_txn(7'(64 + $urandom_range(0, 63)), 0, 0);
                2: do_txn(7'(64 + $urandom_range(0, 63)), 1, 16'($urandom));
                default: do_txn(7'($urandom_range(0, 63)), 0, 0);
            endcase
            repeat ($urandom_range(0, 4)) tick();
        end
        daddr = 7'h14; den = 1'b1;
        tick();
        den = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        seq_on = 0;
        #1;
        chk("arst_drdy", 32'(drdy), 0);
        chk("arst_do", 32'(dout), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_eoc", 32'(eoc), 0);
        chk("arst_chan", 32'(chan), 0);
`ifdef XADC_DRP_ERR_EN
        chk("arst_err", 32'(drp_err), 0);
`endif
        tick();
        tick();
        release_rst();
        p = 0;
        repeat (20) begin
            tick();
            p += int'(drdy);
        end
        chk("abort_no_drdy", p, 0);
        do_txn(7'h45, 0, 0);
        chk("cfg_cleared", 32'(last_rd), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
